// File: rtl/l15_dcache_line_assembler.sv
// Collects L1.5 return beats (optionally byte-swapped) into one D-cache refill line,
// carrying the first beat's TID and an error flag that covers every beat of the line.
module l15_dcache_line_assembler #(
  parameter int unsigned LineWidth = 128,
  parameter int unsigned BeatWidth = 64,
  parameter bit          BigEndian = 1'b1,
  parameter int unsigned TidWidth  = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 rtrn_valid_i,
  output logic                 rtrn_ready_o,
  input  logic [BeatWidth-1:0] rtrn_data_i,
  input  logic [TidWidth-1:0]  rtrn_tid_i,
  input  logic                 rtrn_err_i,
  output logic                 line_valid_o,
  input  logic                 line_ready_i,
  output logic [LineWidth-1:0] line_data_o,
  output logic [TidWidth-1:0]  line_tid_o,
  output logic                 line_err_o,
  output logic                 busy_o
);

  localparam int unsigned NumBeats  = LineWidth / BeatWidth;
  localparam int unsigned CntW      = (NumBeats > 1) ? $clog2(NumBeats) : 1;
  localparam int unsigned BeatBytes = BeatWidth / 8;

  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] FULL    = 1'b1;

  if ((LineWidth % BeatWidth) != 0) begin : g_bad_line_width
    $error("LineWidth must be a multiple of BeatWidth");
  end
  if ((BeatWidth % 8) != 0) begin : g_bad_beat_width
    $error("BeatWidth must be a multiple of 8");
  end
  if ((NumBeats < 1) || ((NumBeats & (NumBeats - 1)) != 0)) begin : g_bad_num_beats
    $error("NumBeats must be a power of two");
  end

  logic [0:0]           state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [LineWidth-1:0] data_q, data_d;
  logic [TidWidth-1:0]  tid_q, tid_d;
  logic                 err_q, err_d;
  logic                 valid_q, valid_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic [BeatWidth-1:0] beat_sw;
  logic                 accept;
  logic                 consume;

  // Big-endian NoC: byte j of the beat lands in byte BeatBytes-1-j.
  if (BigEndian) begin : g_swap
    for (genvar j = 0; j < BeatBytes; j++) begin : g_byte
      assign beat_sw[8*(BeatBytes-1-j) +: 8] = rtrn_data_i[8*j +: 8];
    end
  end else begin : g_pass
    assign beat_sw = rtrn_data_i;
  end

  assign accept  = rtrn_valid_i && ready_q;
  assign consume = valid_q && line_ready_i;

  // Next-state and registered-output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    tid_d   = tid_q;
    err_d   = err_q;
    case (state_q)
      COLLECT: begin
        if (accept) begin
          data_d[cnt_q*BeatWidth +: BeatWidth] = beat_sw;
          if (cnt_q == '0) begin
            tid_d = rtrn_tid_i;
            err_d = rtrn_err_i;
          end else begin
            err_d = err_q | rtrn_err_i | (rtrn_tid_i != tid_q);
          end
          if (cnt_q == CntW'(NumBeats - 1)) begin
            cnt_d   = '0;
            state_d = FULL;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      FULL: begin
        if (consume) state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
    valid_d = (state_d == FULL);
    ready_d = (state_d == COLLECT);
    busy_d  = (state_d == COLLECT) && (cnt_d != '0);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
      data_q  <= '0;
      tid_q   <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      tid_q   <= tid_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign rtrn_ready_o = ready_q;
  assign line_valid_o = valid_q;
  assign line_data_o  = data_q;
  assign line_tid_o   = tid_q;
  assign line_err_o   = err_q;
  assign busy_o       = busy_q;

  // Handshake stability checks on both interfaces.
  a_rtrn_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (rtrn_valid_i && !rtrn_ready_o) |=> $stable(rtrn_data_i))
    else $error("rtrn_data_i changed while stalled");

  a_line_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (line_valid_o && !line_ready_i) |=>
      (line_valid_o && $stable(line_data_o) && $stable(line_tid_o) && $stable(line_err_o)))
    else $error("line outputs changed while stalled");

endmodule

// File: tb/tb_l15_dcache_line_assembler.sv
// Directed bench: default, little-endian and 512-bit line variants of the assembler.
module tb_l15_dcache_line_assembler;

  logic clk = 1'b0;
  logic rst_ni;
  always #5 clk = ~clk;

  // Shared inputs for the big-endian (a) and little-endian (b) 128-bit instances.
  logic        rtrn_valid, line_ready, rtrn_err;
  logic [63:0] rtrn_data;
  logic [1:0]  rtrn_tid;

  logic         a_rdy, a_lvalid, a_lerr, a_busy;
  logic [127:0] a_ldata;
  logic [1:0]   a_ltid;
  logic         b_rdy, b_lvalid, b_lerr, b_busy;
  logic [127:0] b_ldata;
  logic [1:0]   b_ltid;

  logic         c_valid, c_lready;
  logic [63:0]  c_data;
  logic         c_rdy, c_lvalid, c_lerr, c_busy;
  logic [511:0] c_ldata;
  logic [1:0]   c_ltid;

  l15_dcache_line_assembler #(.LineWidth(128), .BeatWidth(64), .BigEndian(1'b1), .TidWidth(2)) u_a (
    .clk_i(clk), .rst_ni(rst_ni),
    .rtrn_valid_i(rtrn_valid), .rtrn_ready_o(a_rdy), .rtrn_data_i(rtrn_data),
    .rtrn_tid_i(rtrn_tid), .rtrn_err_i(rtrn_err),
    .line_valid_o(a_lvalid), .line_ready_i(line_ready), .line_data_o(a_ldata),
    .line_tid_o(a_ltid), .line_err_o(a_lerr), .busy_o(a_busy)
  );

  l15_dcache_line_assembler #(.LineWidth(128), .BeatWidth(64), .BigEndian(1'b0), .TidWidth(2)) u_b (
    .clk_i(clk), .rst_ni(rst_ni),
    .rtrn_valid_i(rtrn_valid), .rtrn_ready_o(b_rdy), .rtrn_data_i(rtrn_data),
    .rtrn_tid_i(rtrn_tid), .rtrn_err_i(rtrn_err),
    .line_valid_o(b_lvalid), .line_ready_i(line_ready), .line_data_o(b_ldata),
    .line_tid_o(b_ltid), .line_err_o(b_lerr), .busy_o(b_busy)
  );

  l15_dcache_line_assembler #(.LineWidth(512), .BeatWidth(64), .BigEndian(1'b1), .TidWidth(2)) u_c (
    .clk_i(clk), .rst_ni(rst_ni),
    .rtrn_valid_i(c_valid), .rtrn_ready_o(c_rdy), .rtrn_data_i(c_data),
    .rtrn_tid_i(2'd0), .rtrn_err_i(1'b0),
    .line_valid_o(c_lvalid), .line_ready_i(c_lready), .line_data_o(c_ldata),
    .line_tid_o(c_ltid), .line_err_o(c_lerr), .busy_o(c_busy)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat to instances a/b for a single edge; it must be accepted.
  task automatic send(input logic [63:0] d, input logic [1:0] t, input logic e);
    rtrn_valid = 1'b1;
    rtrn_data  = d;
    rtrn_tid   = t;
    rtrn_err   = e;
    check("send_ready", 512'(a_rdy), 512'(1'b1));
    step();
    rtrn_valid = 1'b0;
  endtask

  logic [511:0] exp_c;

  initial begin
    rst_ni = 1'b0;
    rtrn_valid = 1'b0; rtrn_data = '0; rtrn_tid = '0; rtrn_err = 1'b0; line_ready = 1'b1;
    c_valid = 1'b0; c_data = '0; c_lready = 1'b1;
    #12;
    rst_ni = 1'b1;
    #1;
    check("rst_ready", 512'(a_rdy), 512'(1'b1));
    check("rst_valid", 512'(a_lvalid), 512'(1'b0));
    check("rst_data", 512'(a_ldata), 512'(128'h0));
    check("rst_tid_err", 512'({a_ltid, a_lerr}), 512'(3'b000));
    check("rst_busy", 512'(a_busy), 512'(1'b0));
    step();

    // Basic two-beat line, both endiannesses.
    send(64'h0011223344556677, 2'd2, 1'b0);
    check("t1_busy", 512'(a_busy), 512'(1'b1));
    check("t1_novalid", 512'(a_lvalid), 512'(1'b0));
    send(64'h8899AABBCCDDEEFF, 2'd2, 1'b0);
    check("t1_valid", 512'(a_lvalid), 512'(1'b1));
    check("t1_data_be", 512'(a_ldata), 512'(128'hFFEEDDCCBBAA9988_7766554433221100));
    check("t1_data_le", 512'(b_ldata), 512'(128'h8899AABBCCDDEEFF_0011223344556677));
    check("t1_tid", 512'(a_ltid), 512'(2'd2));
    check("t1_err", 512'(a_lerr), 512'(1'b0));
    check("t1_full_ready", 512'(a_rdy), 512'(1'b0));
    check("t1_busy_full", 512'(a_busy), 512'(1'b0));
    step();
    check("t1_valid_drop", 512'(a_lvalid), 512'(1'b0));
    check("t1_ready_back", 512'(a_rdy), 512'(1'b1));

    // Back-pressure with a third beat waiting.
    line_ready = 1'b0;
    send(64'h0011223344556677, 2'd1, 1'b0);
    send(64'h8899AABBCCDDEEFF, 2'd1, 1'b0);
    rtrn_valid = 1'b1; rtrn_data = 64'h0123456789ABCDEF; rtrn_tid = 2'd0; rtrn_err = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 512'(a_lvalid), 512'(1'b1));
      check("bp_ready", 512'(a_rdy), 512'(1'b0));
      check("bp_data", 512'(a_ldata), 512'(128'hFFEEDDCCBBAA9988_7766554433221100));
      step();
    end
    line_ready = 1'b1;
    step();
    check("bp_consumed", 512'(a_lvalid), 512'(1'b0));
    check("bp_not_taken", 512'(a_busy), 512'(1'b0));
    check("bp_ready_back", 512'(a_rdy), 512'(1'b1));
    step();
    check("bp_third_taken", 512'(a_busy), 512'(1'b1));
    rtrn_valid = 1'b0;
    send(64'h0, 2'd0, 1'b0);
    check("bp_line_valid", 512'(a_lvalid), 512'(1'b1));
    check("bp_line_data", 512'(a_ldata), 512'(128'h0000000000000000_EFCDAB8967452301));
    check("bp_line_tid_err", 512'({a_ltid, a_lerr}), 512'(3'b000));
    step();

    // TID mismatch and error propagation.
    send(64'h1, 2'd1, 1'b0);
    send(64'h2, 2'd3, 1'b0);
    check("tid_mm_err", 512'(a_lerr), 512'(1'b1));
    check("tid_mm_tid", 512'(a_ltid), 512'(2'd1));
    step();
    send(64'h3, 2'd2, 1'b0);
    send(64'h4, 2'd2, 1'b1);
    check("beat_err", 512'(a_lerr), 512'(1'b1));
    check("beat_err_tid", 512'(a_ltid), 512'(2'd2));
    step();
    send(64'h5, 2'd3, 1'b0);
    send(64'h6, 2'd3, 1'b0);
    check("err_cleared", 512'(a_lerr), 512'(1'b0));
    step();

    // Eight-beat 512-bit line.
    exp_c = '0;
    for (int k = 0; k < 8; k++) begin
      c_valid = 1'b1;
      c_data  = 64'(k);
      exp_c[64*k+56 +: 8] = 8'(k);
      check("p_ready", 512'(c_rdy), 512'(1'b1));
      step();
      c_valid = 1'b0;
      if (k < 7) check("p_busy", 512'(c_busy), 512'(1'b1));
    end
    check("p_busy_done", 512'(c_busy), 512'(1'b0));
    check("p_valid", 512'(c_lvalid), 512'(1'b1));
    check("p_data", c_ldata, exp_c);
    step();
    check("p_consumed", 512'(c_lvalid), 512'(1'b0));

    // Asynchronous reset mid-line discards the partial line.
    send(64'hAAAAAAAAAAAAAAAA, 2'd3, 1'b1);
    check("r_busy_pre", 512'(a_busy), 512'(1'b1));
    #2;
    rst_ni = 1'b0;
    #1;
    check("r_busy", 512'(a_busy), 512'(1'b0));
    check("r_valid", 512'(a_lvalid), 512'(1'b0));
    check("r_data", 512'(a_ldata), 512'(128'h0));
    check("r_tid_err", 512'({a_ltid, a_lerr}), 512'(3'b000));
    check("r_ready", 512'(a_rdy), 512'(1'b1));
    @(negedge clk);
    rst_ni = 1'b1;
    step();
    send(64'h0102030405060708, 2'd1, 1'b0);
    send(64'h1112131415161718, 2'd1, 1'b0);
    check("r_line_valid", 512'(a_lvalid), 512'(1'b1));
    check("r_line_data", 512'(a_ldata), 512'(128'h1817161514131211_0807060504030201));
    check("r_line_tid_err", 512'({a_ltid, a_lerr}), 512'(3'b010));
    step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
